// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic intersection controller: state codes,
// lamp encodings, default phase durations and small decode helpers.
package traffic_pkg;

  // FSM state encodings (also driven out on phase_o for debug)
  localparam logic [2:0] ST_A_GREEN  = 3'd0;
  localparam logic [2:0] ST_A_YELLOW = 3'd1;
  localparam logic [2:0] ST_RED_AB   = 3'd2;
  localparam logic [2:0] ST_B_GREEN  = 3'd3;
  localparam logic [2:0] ST_B_YELLOW = 3'd4;
  localparam logic [2:0] ST_RED_BA   = 3'd5;

  // One-hot lamp encodings
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;

  // Default durations, in ticks, and default phase-counter width
  localparam int DEF_GREEN_A_MIN = 6;
  localparam int DEF_GREEN_B     = 4;
  localparam int DEF_YELLOW_T    = 2;
  localparam int DEF_ALLRED_T    = 1;
  localparam int DEF_CNT_W       = 4;

  // Pair of lamp values for both roads
  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
  } lamp_pair_t;

  // Lamp decode for a state; unknown codes show red on both roads so the
  // single recovery cycle never displays a conflicting green.
  function automatic lamp_pair_t lamps_for(input logic [2:0] st);
    lamp_pair_t lp;
    lp.a = LAMP_RED;
    lp.b = LAMP_RED;
    case (st)
      ST_A_GREEN:  lp.a = LAMP_GREEN;
      ST_A_YELLOW: lp.a = LAMP_YELLOW;
      ST_B_GREEN:  lp.b = LAMP_GREEN;
      ST_B_YELLOW: lp.b = LAMP_YELLOW;
      default:     ;
    endcase
    return lp;
  endfunction

  // Successor of each timed state once its duration has elapsed.
  // A_GREEN is gated by the request latch and handled in the FSM itself.
  function automatic logic [2:0] next_timed_state(input logic [2:0] st);
    logic [2:0] nx;
    case (st)
      ST_A_GREEN:  nx = ST_A_YELLOW;
      ST_A_YELLOW: nx = ST_RED_AB;
      ST_RED_AB:   nx = ST_B_GREEN;
      ST_B_GREEN:  nx = ST_B_YELLOW;
      ST_B_YELLOW: nx = ST_RED_BA;
      ST_RED_BA:   nx = ST_A_GREEN;
      default:     nx = ST_A_GREEN;
    endcase
    return nx;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase timer: counts ticks from zero, saturates at the terminal value and
// flags done in any tick cycle where the count sits at the terminal value.
module phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             done_o
);

  logic [CNT_W-1:0] r_count;
  logic             w_at_term;

  assign w_at_term = (r_count == term_i);
  assign done_o    = tick_i & w_at_term;

  // Clear on state change, otherwise count ticks up to the terminal value
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= '0;
    end else if (tick_i && !w_at_term) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection controller. Road A rests on green; a vehicle on road B
// or a pedestrian request starts one full B cycle once A's minimum green has
// elapsed. All timing advances only on tick_i.
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int GREEN_A_MIN = DEF_GREEN_A_MIN,
  parameter int GREEN_B     = DEF_GREEN_B,
  parameter int YELLOW_T    = DEF_YELLOW_T,
  parameter int ALLRED_T    = DEF_ALLRED_T,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       b_req_i,
  input  logic       ped_req_i,
  output logic [2:0] a_lamp_o,
  output logic [2:0] b_lamp_o,
  output logic       walk_o,
  output logic [2:0] phase_o
);

  // Terminal counter values: a phase lasting N ticks ends when the count is N-1
  localparam logic [CNT_W-1:0] TERM_A_GREEN = CNT_W'(GREEN_A_MIN - 1);
  localparam logic [CNT_W-1:0] TERM_B_GREEN = CNT_W'(GREEN_B - 1);
  localparam logic [CNT_W-1:0] TERM_YELLOW  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] TERM_ALLRED  = CNT_W'(ALLRED_T - 1);

  logic [2:0]       r_state;
  logic [2:0]       w_state_next;
  logic             r_req_pend;
  logic             w_req_pend_next;
  logic             r_ped_pend;
  logic             w_ped_pend_next;
  logic [CNT_W-1:0] w_term;
  logic             w_done;
  logic             w_state_change;
  logic             w_enter_b_green;
  logic             w_leave_b_green;
  lamp_pair_t       w_lamps;

  // Terminal value for the phase currently being timed
  always_comb begin
    w_term = TERM_A_GREEN;
    case (r_state)
      ST_A_YELLOW, ST_B_YELLOW: w_term = TERM_YELLOW;
      ST_RED_AB, ST_RED_BA:     w_term = TERM_ALLRED;
      ST_B_GREEN:               w_term = TERM_B_GREEN;
      default:                  ;
    endcase
  end

  // The counter restarts whenever the state moves, including recovery moves
  assign w_state_change = (w_state_next != r_state);

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .tick_i  (tick_i),
    .clear_i (w_state_change),
    .term_i  (w_term),
    .done_o  (w_done)
  );

  // Next-state: timed states step on done, A_GREEN also needs a request,
  // unknown codes fall back to A_GREEN immediately
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_A_GREEN: begin
        if (w_done && r_req_pend) begin
          w_state_next = next_timed_state(r_state);
        end
      end
      ST_A_YELLOW, ST_RED_AB, ST_B_GREEN, ST_B_YELLOW, ST_RED_BA: begin
        if (w_done) begin
          w_state_next = next_timed_state(r_state);
        end
      end
      default: w_state_next = ST_A_GREEN;
    endcase
  end

  assign w_enter_b_green = (r_state == ST_RED_AB)  && (w_state_next == ST_B_GREEN);
  assign w_leave_b_green = (r_state == ST_B_GREEN) && (w_state_next != ST_B_GREEN);

  // Request latch: any request is remembered until the B phase starts;
  // requests arriving on that very cycle count as served
  assign w_req_pend_next = (r_req_pend | b_req_i | ped_req_i) & ~w_enter_b_green;

  // Pedestrian latch: a press during B_GREEN is not taken for the current
  // walk window (it still raises req_pend for the next cycle)
  always_comb begin
    w_ped_pend_next = r_ped_pend | (ped_req_i & (r_state != ST_B_GREEN));
    if (w_leave_b_green) begin
      w_ped_pend_next = 1'b0;
    end
  end

  // State and request latches
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_A_GREEN;
      r_req_pend <= 1'b0;
      r_ped_pend <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_req_pend <= w_req_pend_next;
      r_ped_pend <= w_ped_pend_next;
    end
  end

  // Output decode straight from state and latches
  assign w_lamps  = lamps_for(r_state);
  assign a_lamp_o = w_lamps.a;
  assign b_lamp_o = w_lamps.b;
  assign walk_o   = (r_state == ST_B_GREEN) & r_ped_pend;
  assign phase_o  = r_state;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Bench for traffic_intersection_ctrl: directed scenarios plus random stimulus,
// every cycle compared against a countdown-based behavioural model.
module tb_traffic_intersection_ctrl;
  import traffic_pkg::*;

  logic       clk_i     = 1'b0;
  logic       rst_ni    = 1'b0;
  logic       tick_i    = 1'b0;
  logic       b_req_i   = 1'b0;
  logic       ped_req_i = 1'b0;
  logic [2:0] a_lamp_o;
  logic [2:0] b_lamp_o;
  logic       walk_o;
  logic [2:0] phase_o;

  traffic_intersection_ctrl dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .tick_i    (tick_i),
    .b_req_i   (b_req_i),
    .ped_req_i (ped_req_i),
    .a_lamp_o  (a_lamp_o),
    .b_lamp_o  (b_lamp_o),
    .walk_o    (walk_o),
    .phase_o   (phase_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Phase order: A_GREEN, A_YELLOW, RED_AB, B_GREEN, B_YELLOW, RED_BA
  int         dur   [6] = '{6, 2, 1, 4, 2, 1};
  logic [2:0] exp_a [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] exp_b [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [2:0] codes [6] = '{ST_A_GREEN, ST_A_YELLOW, ST_RED_AB, ST_B_GREEN, ST_B_YELLOW, ST_RED_BA};

  // Model: phase index, ticks still to wait before the phase may end,
  // and the two request memories
  int m_phase;
  int m_left;
  bit m_req;
  bit m_ped;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_left  = dur[0] - 1;
    m_req   = 1'b0;
    m_ped   = 1'b0;
  endtask

  // One clock of the reference behaviour
  task automatic model_step(input bit t, input bit b, input bit p);
    bit exit_now;
    int old_phase;
    exit_now  = 1'b0;
    old_phase = m_phase;
    if (t) begin
      if (m_left == 0) exit_now = (m_phase != 0) || m_req;
      else             m_left   = m_left - 1;
    end
    m_req = (m_req | b | p) & !(exit_now && old_phase == 2);
    if (exit_now && old_phase == 3) m_ped = 1'b0;
    else                            m_ped = m_ped | (p && old_phase != 3);
    if (exit_now) begin
      m_phase = (old_phase + 1) % 6;
      m_left  = dur[m_phase] - 1;
    end
  endtask

  task automatic check_outputs();
    chk("a_lamp", 32'(a_lamp_o), 32'(exp_a[m_phase]));
    chk("b_lamp", 32'(b_lamp_o), 32'(exp_b[m_phase]));
    chk("walk",   32'(walk_o),   32'(m_phase == 3 && m_ped));
    chk("phase",  32'(phase_o),  32'(codes[m_phase]));
  endtask

  // Called at a falling edge: drive, compare, clock, advance the model
  task automatic step(input bit t, input bit b, input bit p);
    tick_i    = t;
    b_req_i   = b;
    ped_req_i = p;
    check_outputs();
    @(posedge clk_i);
    if (rst_ni) model_step(t, b, p);
    else        model_reset();
    @(negedge clk_i);
    cyc++;
  endtask

  // Step with the regular timebase: a tick every fourth clock
  task automatic tstep(input bit b, input bit p);
    step(cyc % 4 == 0, b, p);
  endtask

  int  cnt_a;
  int  cnt_b;
  int  entries;
  bit  was_bg;
  bit  reached;

  initial begin
    model_reset();
    @(negedge clk_i);

    // Reset state held for a few clocks
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1);
    rst_ni = 1'b1;
    $display("scenario reset: done, %0d checks so far", n_checks);

    // 20 ticks, no requests
    for (int i = 0; i < 80; i++) tstep(1'b0, 1'b0);
    chk("idle_phase", 32'(phase_o), 32'(ST_A_GREEN));
    $display("scenario idle: done, %0d checks so far", n_checks);

    // Vehicle pulse: exactly 4 B_GREEN ticks, no walk
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 100; i++) begin
      if (tick_i && phase_o == ST_B_GREEN) cnt_a++;
      if (walk_o) cnt_b++;
      tstep(i == 8, 1'b0);
    end
    chk("bveh_bgreen_ticks", 32'(cnt_a), 32'd4);
    chk("bveh_walk_cycles",  32'(cnt_b), 32'd0);
    $display("scenario vehicle pulse: done, %0d checks so far", n_checks);

    // Pedestrian pulse: walk for exactly the 4 B_GREEN ticks
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 100; i++) begin
      if (tick_i && walk_o) cnt_a++;
      if (walk_o && phase_o != ST_B_GREEN) cnt_b++;
      tstep(1'b0, i == 5);
    end
    chk("ped_walk_ticks", 32'(cnt_a), 32'd4);
    chk("ped_walk_outside_bgreen", 32'(cnt_b), 32'd0);
    $display("scenario pedestrian pulse: done, %0d checks so far", n_checks);

    // Request during B_GREEN triggers a second B phase
    entries = 0; was_bg = 1'b0; reached = 1'b0;
    tstep(1'b1, 1'b0);
    for (int i = 0; i < 200 && !reached; i++) begin
      if (phase_o == ST_B_GREEN && !was_bg) entries++;
      was_bg = (phase_o == ST_B_GREEN);
      if (m_phase == 3) reached = 1'b1;
      else tstep(1'b0, 1'b0);
    end
    chk("bgreen_reached", 32'(reached), 32'd1);
    for (int i = 0; i < 150; i++) begin
      if (phase_o == ST_B_GREEN && !was_bg) entries++;
      was_bg = (phase_o == ST_B_GREEN);
      tstep(i == 2, 1'b0);
    end
    chk("second_b_phase_entries", 32'(entries), 32'd2);
    $display("scenario request in B_GREEN: done, %0d checks so far", n_checks);

    // Asynchronous reset in the middle of B_GREEN
    reached = 1'b0;
    tstep(1'b0, 1'b1);
    for (int i = 0; i < 200 && !reached; i++) begin
      if (m_phase == 3 && m_left < dur[3] - 1) reached = 1'b1;
      else tstep(1'b0, 1'b0);
    end
    chk("midb_reached", 32'(reached), 32'd1);
    tick_i = 1'b0; b_req_i = 1'b0; ped_req_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_a_lamp", 32'(a_lamp_o), 32'(3'b001));
    chk("async_rst_b_lamp", 32'(b_lamp_o), 32'(3'b100));
    chk("async_rst_walk",   32'(walk_o),   32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    model_reset();
    rst_ni = 1'b1;
    entries = 0;
    for (int i = 0; i < 120; i++) begin
      if (phase_o != ST_A_GREEN) entries++;
      tstep(1'b0, 1'b0);
    end
    chk("post_reset_no_b_phase", 32'(entries), 32'd0);
    $display("scenario mid-phase reset: done, %0d checks so far", n_checks);

    // Timebase stalled with requests pending
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 60; i++) step(1'b0, (i % 7) == 0, 1'b0);
    chk("stall_phase", 32'(phase_o), 32'(ST_A_GREEN));
    step(1'b1, 1'b0, 1'b0);
    chk("first_tick_after_stall", 32'(phase_o), 32'(ST_A_YELLOW));
    for (int i = 0; i < 80; i++) step(i % 4 == 3, 1'b0, 1'b0);
    $display("scenario tick stall: done, %0d checks so far", n_checks);

    // Random traffic with an irregular timebase
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 2) == 0,
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 39) == 0);
    end
    $display("scenario random: done, %0d checks so far", n_checks);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_intersection_ctrl.md
TRAFFIC_INTERSECTION_CTRL -- requirements
Module: traffic_intersection_ctrl

Interface
REQ-001 Parameter GREEN_A_MIN, default 6: minimum main-road (A) green duration, in ticks.
REQ-002 Parameter GREEN_B, default 4: side-road (B) green duration, in ticks.
REQ-003 Parameter YELLOW_T, default 2: yellow duration for either road, in ticks.
REQ-004 Parameter ALLRED_T, default 1: all-red clearance duration, in ticks.
REQ-005 Parameter CNT_W, default 4: phase-counter width; every duration parameter SHALL be >= 1 and <= 2^CNT_W.
REQ-006 clk_i  input  1  clock; rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 tick_i  input  1  single-cycle timebase enable; all timing advances only in cycles where it is 1.
REQ-008 b_req_i  input  1  vehicle sensor on road B; level or pulse.
REQ-009 ped_req_i  input  1  pedestrian crossing button; level or pulse.
REQ-010 a_lamp_o  output  3  road-A lamp, one-hot: 001 green, 010 yellow, 100 red.
REQ-011 b_lamp_o  output  3  road-B lamp, same encoding as a_lamp_o.
REQ-012 walk_o  output  1  pedestrian walk indication.
REQ-013 phase_o  output  3  current state encoding, for debug.

Function
REQ-014 The FSM SHALL have six states: A_GREEN, A_YELLOW, RED_AB, B_GREEN, B_YELLOW, RED_BA.
REQ-015 The state and the phase counter SHALL be registered; lamp outputs, walk_o and phase_o SHALL be decoded combinationally from the state and latches only.
REQ-016 Lamps per state: A_GREEN A=001 B=100; A_YELLOW A=010 B=100; RED_AB and RED_BA A=100 B=100; B_GREEN A=100 B=001; B_YELLOW A=100 B=010.
REQ-017 The phase counter SHALL reset to 0 on every state change and increment by 1 on each tick_i while the state holds.
REQ-018 Timed states (A_YELLOW, RED_AB, B_GREEN, B_YELLOW, RED_BA) SHALL advance in a tick_i cycle where the counter equals duration-1.
REQ-019 The timed-state order SHALL be A_YELLOW->RED_AB->B_GREEN->B_YELLOW->RED_BA->A_GREEN.
REQ-020 In A_GREEN the counter SHALL saturate at GREEN_A_MIN-1.
REQ-021 A_GREEN SHALL exit to A_YELLOW in a tick_i cycle only when the counter is saturated and req_pend=1.
REQ-022 With no pending request, A_GREEN SHALL hold indefinitely.
REQ-023 req_pend latch: req_pend_next = (req_pend | b_req_i | ped_req_i) & ~(transition into B_GREEN); a request asserted during the transition cycle is dropped as served.
REQ-024 A request asserted during B_GREEN or later SHALL be served in the following cycle.
REQ-025 ped_pend latch: set by ped_req_i in any state except B_GREEN; cleared on the transition out of B_GREEN.
REQ-026 walk_o SHALL be 1 only in B_GREEN with ped_pend=1.
REQ-027 When tick_i=0, state and counter SHALL hold; latches SHALL still capture requests.
REQ-028 Any undefined phase encoding SHALL recover to A_GREEN on the next clock.

Reset
REQ-029 While rst_ni=0: state=A_GREEN, counter=0, req_pend=0, ped_pend=0; hence a_lamp_o=001, b_lamp_o=100, walk_o=0, phase_o=A_GREEN code.
REQ-030 Reset asserted mid-phase SHALL take effect immediately (asynchronously), discarding all pending requests.
REQ-031 Operation SHALL resume on the first clock after rst_ni deasserts.

Structure
REQ-032 The state encodings, the lamp constants (GREEN=001, YELLOW=010, RED=100) and the default durations SHALL live in a shared package, traffic_pkg.
REQ-033 The saturating/terminal-count phase timer is the one natural sub-module: phase_timer (inputs: tick, clear, terminal value; output: done).

Verification (defaults, tick every 4 clocks)
REQ-034 Reset, no requests, 20 ticks -> phase stays A_GREEN; a_lamp=001, b_lamp=100, walk=0 throughout.
REQ-035 b_req_i 1-cycle pulse at tick 2 -> A_GREEN until 6 ticks after entry, then A_YELLOW 2 ticks, RED_AB 1, B_GREEN 4, B_YELLOW 2, RED_BA 1, then back to A_GREEN with req_pend=0.
REQ-036 ped_req_i pulse -> full cycle as in REQ-035, with walk_o=1 for exactly the 4 B_GREEN ticks and 0 elsewhere.
REQ-037 b_req_i pulse during B_GREEN -> after RED_BA, A_GREEN runs its 6-tick minimum, then a second B phase follows.
REQ-038 rst_ni low for 1 clock mid-B_GREEN -> a_lamp=001 and b_lamp=100 immediately; no B phase after release without a new request.
REQ-039 tick_i held 0 with requests pending -> no state or lamp change; sequence starts on the first subsequent tick.
